// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: state encodings, parity types, widths.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PRESC_W        = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Per-bit edge counter: counts 0..prescale-1 while enabled and pulses bit_done_c on the last edge.
module uart_tx_baud_counter
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               bit_done_c
);

  logic [PRESC_W-1:0] last_edge;

  // Prescale of 0 behaves as 1, so the terminal count never underflows
  assign last_edge  = (prescale == '0) ? '0 : prescale - PRESC_W'(1);
  assign bit_done_c = enable && (edge_cnt == last_edge);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt <= '0;
    end else if (!enable || bit_done_c) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit; each bit lasts Prescale clocks.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic [2:0]            state, state_nx;
  logic [BIT_W-1:0]      bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] data_lat;
  logic                  par_en_lat;
  logic                  par_bit;
  logic [PRESC_W-1:0]    presc_lat;
  logic                  tx_nx;
  logic                  busy_nx;
  logic                  accept;
  logic [PRESC_W-1:0]    edge_cnt;
  logic                  bit_done_c;

  assign accept = (state == ST_IDLE) && Data_Valid;

  uart_tx_baud_counter u_baud (
    .clk        (clk),
    .reset      (reset),
    .enable     (state != ST_IDLE),
    .prescale   (presc_lat),
    .edge_cnt   (edge_cnt),
    .bit_done_c (bit_done_c)
  );

  // Frame sequencing; TX_OUT and Busy are derived from the next state so both stay registered
  always_comb begin
    state_nx = state;
    bit_nx   = bit_cnt;
    tx_nx    = 1'b1;
    busy_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Data_Valid) begin
          state_nx = ST_START;
          bit_nx   = '0;
        end
      end
      ST_START: begin
        if (bit_done_c) begin
          state_nx = ST_DATA;
          bit_nx   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done_c) begin
          if (bit_cnt == LAST_BIT) begin
            state_nx = par_en_lat ? ST_PARITY : ST_STOP;
          end else begin
            bit_nx = bit_cnt + BIT_W'(1);
          end
        end
      end
      ST_PARITY: if (bit_done_c) state_nx = ST_STOP;
      ST_STOP:   if (bit_done_c) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase

    case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = data_lat[bit_nx];
      ST_PARITY: tx_nx = par_bit;
      default:   tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      TX_OUT  <= 1'b1;
      Busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_nx;
      TX_OUT  <= tx_nx;
      Busy    <= busy_nx;
    end
  end

  // Frame parameters are frozen at acceptance so mid-frame input changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_lat   <= '0;
      par_en_lat <= 1'b0;
      par_bit    <= 1'b0;
      presc_lat  <= '0;
    end else if (accept) begin
      data_lat   <= P_DATA;
      par_en_lat <= PAR_EN;
      par_bit    <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
      presc_lat  <= Prescale;
    end
  end

  // The edge count never passes the latched prescale
  a_edge_bound: assert property (@(posedge clk) disable iff (reset)
    (edge_cnt == '0) || (edge_cnt < presc_lat));

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: expected per-cycle {Busy,TX_OUT} pairs are queued at stimulus time.
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // Reference frame model: every bit repeated max(p,1) times with Busy high, then one idle cycle
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int p);
    int pn = (p == 0) ? 1 : p;
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ? ~^d : ^d);
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (pn) exp_q.push_back({1'b1, bits[i]});
    exp_q.push_back(2'b01);
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
    @(negedge clk);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = p; Data_Valid = 1'b1;
    @(posedge clk);
    #1 Data_Valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", TX_OUT); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (TX_OUT !== 1'b1) begin errors++; $display("FAIL idle_tx: got %b want 1", TX_OUT); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_basic();
    logic [9:0] seq = 10'b1101001010;
    logic [1:0] e;
    int n = 0;
    int busy_cnt = 0;
    for (int i = 0; i < 10; i++) repeat (4) exp_q.push_back({1'b1, seq[i]});
    exp_q.push_back(2'b01);
    start_frame(8'hA5, 1'b0, 1'b0, 6'd4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (Busy === 1'b1) busy_cnt++;
      checks++;
      if ({Busy, TX_OUT} !== e) begin
        errors++; $display("FAIL basic cycle %0d: busy,tx=%b want %b", n, {Busy, TX_OUT}, e);
      end
      n++;
    end
    checks++; if (busy_cnt != 40) begin errors++; $display("FAIL basic_busy_len: got %0d want 40", busy_cnt); end
  endtask

  task automatic test_parity(input logic pt);
    logic [1:0] e;
    int n = 0;
    int busy_cnt = 0;
    push_frame(8'h07, 1'b1, pt, 8);
    start_frame(8'h07, 1'b1, pt, 6'd8);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (Busy === 1'b1) busy_cnt++;
      checks++;
      if ({Busy, TX_OUT} !== e) begin
        errors++; $display("FAIL parity%0d cycle %0d: busy,tx=%b want %b", pt, n, {Busy, TX_OUT}, e);
      end
      if (n == 76) begin
        checks++;
        if (TX_OUT !== ~pt) begin errors++; $display("FAIL parity_bit typ=%0d: got %b want %b", pt, TX_OUT, ~pt); end
      end
      n++;
    end
    checks++; if (busy_cnt != 88) begin errors++; $display("FAIL parity_busy_len typ=%0d: got %0d want 88", pt, busy_cnt); end
  endtask

  task automatic test_midframe();
    logic [1:0] e;
    int n = 0;
    push_frame(8'h5A, 1'b0, 1'b0, 4);
    repeat (12) exp_q.push_back(2'b01);
    start_frame(8'h5A, 1'b0, 1'b0, 6'd4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({Busy, TX_OUT} !== e) begin
        errors++; $display("FAIL midframe cycle %0d: busy,tx=%b want %b", n, {Busy, TX_OUT}, e);
      end
      if (n == 15) begin
        Data_Valid = 1'b1; P_DATA = 8'hFF; Prescale = 6'd2; PAR_EN = 1'b1;
      end
      if (n == 16) Data_Valid = 1'b0;
      n++;
    end
    PAR_EN = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [1:0] e;
    int n = 0;
    push_frame(8'h00, 1'b0, 1'b0, 4);
    start_frame(8'h00, 1'b0, 1'b0, 6'd4);
    while (n < 14) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({Busy, TX_OUT} !== e) begin
        errors++; $display("FAIL pre_reset cycle %0d: busy,tx=%b want %b", n, {Busy, TX_OUT}, e);
      end
      n++;
    end
    #1 reset = 1'b1;
    #1;
    checks++; if (TX_OUT !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", TX_OUT); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", Busy); end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    push_frame(8'h3C, 1'b0, 1'b0, 4);
    start_frame(8'h3C, 1'b0, 1'b0, 6'd4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({Busy, TX_OUT} !== e) begin
        errors++; $display("FAIL post_reset cycle %0d: busy,tx=%b want %b", n, {Busy, TX_OUT}, e);
      end
      n++;
    end
  endtask

  task automatic test_prescale_zero();
    logic [1:0] e;
    int n = 0;
    int busy_cnt = 0;
    push_frame(8'h01, 1'b0, 1'b0, 0);
    start_frame(8'h01, 1'b0, 1'b0, 6'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (Busy === 1'b1) busy_cnt++;
      checks++;
      if ({Busy, TX_OUT} !== e) begin
        errors++; $display("FAIL presc0 cycle %0d: busy,tx=%b want %b", n, {Busy, TX_OUT}, e);
      end
      n++;
    end
    checks++; if (busy_cnt != 10) begin errors++; $display("FAIL presc0_busy_len: got %0d want 10", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    logic tx_prev = 1'b1;
    int n = 0;
    int fall_n = -1;
    push_frame(8'h55, 1'b0, 1'b0, 4);
    push_frame(8'hAA, 1'b0, 1'b0, 4);
    @(negedge clk);
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
    @(posedge clk);
    #1 P_DATA = 8'hAA;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({Busy, TX_OUT} !== e) begin
        errors++; $display("FAIL b2b cycle %0d: busy,tx=%b want %b", n, {Busy, TX_OUT}, e);
      end
      if (n >= 36 && fall_n < 0 && tx_prev === 1'b1 && TX_OUT === 1'b0) fall_n = n;
      if (n == 41) Data_Valid = 1'b0;
      tx_prev = TX_OUT;
      n++;
    end
    checks++;
    if (fall_n - 36 != 5) begin errors++; $display("FAIL b2b_gap: stop-to-start %0d cycles want 5", fall_n - 36); end
  endtask

  initial begin
    Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4;
    test_reset();
    test_basic();
    test_parity(1'b0);
    test_parity(1'b1);
    test_midframe();
    test_reset_midframe();
    test_prescale_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
